jpeg_decoder_axi_writer: RTL and testbench
==========================================

Name: jpeg_decoder_axi_writer

Overview:
- Downstream consumer of the JPEG decoder output FIFO.
- Pops 32-bit pixel words from the FIFO and writes them to memory as AXI-4 INCR write bursts.
- Each burst starts at a programmed base address, for a programmed number of words.
- Issues a burst only when the FIFO already holds the whole burst, so W-channel data never stalls on the FIFO.

Parameters:
- MAX_BURST, 16, maximum beats per AXI burst (power of two, 1..256).
- AXI_ID, 0, constant AWID driven on every burst (4 bits).

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  synchronous active-high reset.
- cfg_start_i  in  1  one-cycle pulse: begin a transfer (ignored unless idle).
- cfg_base_addr_i  in  32  byte address of first word; bits [1:0] ignored (treated as 0).
- cfg_words_i  in  24  number of 32-bit words to write; 0 = complete immediately.
- busy_o  out  1  transfer in progress.
- done_o  out  1  one-cycle pulse when last B response is received.
- error_o  out  1  sticky BRESP error (optional feature).
- fifo_data_i  in  32  FIFO read data.
- fifo_valid_i  in  1  FIFO data valid.
- fifo_level_i  in  11  FIFO occupancy.
- fifo_pop_o  out  1  consume current FIFO word.
- axi_awvalid_o  out  1,  axi_awaddr_o  out  32,  axi_awid_o  out  4,  axi_awlen_o  out  8,  axi_awburst_o  out  2 (=2'b01),  axi_awready_i  in  1.
- axi_wvalid_o  out  1,  axi_wdata_o  out  32,  axi_wstrb_o  out  4 (=4'hF),  axi_wlast_o  out  1,  axi_wready_i  in  1.
- axi_bvalid_i  in  1,  axi_bresp_i  in  2,  axi_bid_i  in  4,  axi_bready_o  out  1 (constant 1).

Behaviour:
- Reset values: busy_o, done_o, error_o, fifo_pop_o, axi_awvalid_o, axi_wvalid_o all 0; address/remaining/length registers 0.
- Reset mid-burst abandons the transfer; no further AW or W is issued.
- **States:** IDLE, CALC, ADDR, DATA, RESP.

State transitions:
- IDLE: on cfg_start_i, latch addr = {base[31:2],2'b00} and remain = cfg_words_i.
  - remain = 0: pulse done_o next cycle and stay IDLE.
  - Otherwise go to CALC and set busy_o.
- CALC: compute len = min(MAX_BURST, remain, (4096 - addr[11:0]) >> 2).
  - Bursts never cross a 4KB boundary.
  - Stay in CALC until fifo_level_i >= len, then go to ADDR.
- ADDR: assert axi_awvalid_o with awaddr = addr and awlen = len - 1.
  - Hold AW stable until axi_awready_i, then go to DATA.
  - AW and W are serialised: W never precedes AW.
- DATA: axi_wvalid_o = fifo_valid_i; axi_wdata_o = fifo_data_i.
  - fifo_pop_o = axi_wvalid_o & axi_wready_i.
  - A beat counter counts accepted beats; axi_wlast_o = 1 when count = len - 1.
  - On the accepted last beat go to RESP.
- RESP: wait for axi_bvalid_i.
  - On B: addr += len*4 and remain -= len.
  - remain = 0: go to IDLE, clear busy_o, pulse done_o.
  - Otherwise go to CALC.

Rules:
- Only one outstanding burst at a time.
- fifo_valid_i may lag fifo_level_i by up to 2 cycles (RAM read latency); W beats simply wait, with no data loss.
- axi_wvalid_o must never assert while fifo_valid_i = 0.
- Address arithmetic wraps modulo 2^32.
- cfg_start_i while busy_o is ignored.

Optional Feature:
- Macro: JPEG_DECODER_AXI_WR_ERROR_EN.
- Enabled:
  - A B response with bresp != 2'b00 sets error_o; error_o is cleared only by rst_i or by cfg_start_i accepted in IDLE.
  - After an error the transfer stops: IDLE, busy_o cleared, done_o pulsed.
  - Data left in the FIFO is not drained.
- Disabled: axi_bresp_i is ignored, error_o is tied 0, and the transfer always completes.

Test Plan:
- Base 0x1000_0000, words 40, FIFO pre-filled with 40, awready/wready always 1 -> three bursts: 0x1000_0000 len 16, 0x1000_0040 len 16, 0x1000_0080 len 8. wlast on beats 16/16/8. Data order preserved. done_o once.
- Base 0x0000_0FF0, words 8 -> burst at 0x0FF0 len 4, then burst at 0x1000 len 4. No 4KB crossing.
- FIFO level rises 1 word per 3 cycles, words 16 -> AW only after level >= 16. wvalid never asserted with fifo_valid_i low. 16 pops total.
- Random awready/wready/bvalid back-pressure, words 100 -> memory model holds 100 words in order. At most one outstanding burst. AW stable while awvalid & !awready.
- words 0 -> done_o pulses 1 cycle after start. No AXI activity. busy_o stays 0.
- Feature enabled: second B returns SLVERR (2'b10), words 48 -> error_o = 1, no third AW, done_o pulses. A subsequent start clears error_o.

Source files
------------

// File: rtl/jpeg_decoder_axi_writer.sv
// Drains the JPEG decoder output FIFO into memory as AXI-4 INCR write bursts, one burst at a time.
// Optional sticky BRESP error handling: define JPEG_DECODER_AXI_WR_ERROR_EN.
module jpeg_decoder_axi_writer #(
    parameter int unsigned MAX_BURST = 16,
    parameter logic [3:0]  AXI_ID    = 4'd0
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        cfg_start_i,
    input  logic [31:0] cfg_base_addr_i,
    input  logic [23:0] cfg_words_i,
    output logic        busy_o,
    output logic        done_o,
    output logic        error_o,
    input  logic [31:0] fifo_data_i,
    input  logic        fifo_valid_i,
    input  logic [10:0] fifo_level_i,
    output logic        fifo_pop_o,
    output logic        axi_awvalid_o,
    output logic [31:0] axi_awaddr_o,
    output logic [3:0]  axi_awid_o,
    output logic [7:0]  axi_awlen_o,
    output logic [1:0]  axi_awburst_o,
    input  logic        axi_awready_i,
    output logic        axi_wvalid_o,
    output logic [31:0] axi_wdata_o,
    output logic [3:0]  axi_wstrb_o,
    output logic        axi_wlast_o,
    input  logic        axi_wready_i,
    input  logic        axi_bvalid_i,
    input  logic [1:0]  axi_bresp_i,
    input  logic [3:0]  axi_bid_i,
    output logic        axi_bready_o
);

    localparam int unsigned LEN_W  = 9;
    localparam int unsigned PAGE_W = 13;

    typedef enum logic [2:0] {S_IDLE, S_CALC, S_ADDR, S_DATA, S_RESP} state_e;

    state_e             state_q, state_d;
    logic [31:0]        addr_q, addr_d;
    logic [23:0]        remain_q, remain_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic [7:0]         beat_q, beat_d;
    logic               done_q, done_d;
    logic               error_q, error_d;

    logic [PAGE_W-1:0]  page_bytes_c;
    logic [PAGE_W-1:0]  page_words_c;
    logic [LEN_W-1:0]   calc_len_c;
    logic [23:0]        remain_next_c;
    logic               wvalid_c;
    logic               wlast_c;
    logic               bresp_err_c;
    logic               unused_c;

`ifdef JPEG_DECODER_AXI_WR_ERROR_EN
    assign bresp_err_c = (axi_bresp_i != 2'b00);
`else
    assign bresp_err_c = 1'b0;
`endif
    assign unused_c = ^{axi_bid_i, axi_bresp_i};

    // Burst length: limited by MAX_BURST, words left, and the distance to the next 4KB page.
    always_comb begin
        page_bytes_c = PAGE_W'(13'd4096 - {1'b0, addr_q[11:0]});
        page_words_c = page_bytes_c >> 2;
        calc_len_c   = LEN_W'(MAX_BURST);
        if (remain_q < 24'(calc_len_c)) begin
            calc_len_c = LEN_W'(remain_q);
        end
        if (page_words_c < PAGE_W'(calc_len_c)) begin
            calc_len_c = LEN_W'(page_words_c);
        end
    end

    assign remain_next_c = remain_q - 24'(len_q);
    assign wvalid_c      = (state_q == S_DATA) && fifo_valid_i;
    assign wlast_c       = (beat_q == 8'(len_q - LEN_W'(1)));

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        remain_d = remain_q;
        len_d    = len_q;
        beat_d   = beat_q;
        done_d   = 1'b0;
        error_d  = error_q;
        unique case (state_q)
            S_IDLE: begin
                if (cfg_start_i) begin
                    addr_d   = {cfg_base_addr_i[31:2], 2'b00};
                    remain_d = cfg_words_i;
                    error_d  = 1'b0;
                    if (cfg_words_i == 24'd0) begin
                        done_d = 1'b1;
                    end else begin
                        state_d = S_CALC;
                    end
                end
            end
            S_CALC: begin
                // Wait until the whole burst is buffered so W never stalls on the FIFO.
                len_d = calc_len_c;
                if (fifo_level_i >= 11'(calc_len_c)) begin
                    state_d = S_ADDR;
                end
            end
            S_ADDR: begin
                if (axi_awready_i) begin
                    beat_d  = 8'd0;
                    state_d = S_DATA;
                end
            end
            S_DATA: begin
                if (wvalid_c && axi_wready_i) begin
                    if (wlast_c) begin
                        state_d = S_RESP;
                    end else begin
                        beat_d = beat_q + 8'd1;
                    end
                end
            end
            S_RESP: begin
                if (axi_bvalid_i) begin
                    addr_d   = addr_q + {21'd0, len_q, 2'b00};
                    remain_d = remain_next_c;
                    if (bresp_err_c) begin
                        error_d = 1'b1;
                        done_d  = 1'b1;
                        state_d = S_IDLE;
                    end else if (remain_next_c == 24'd0) begin
                        done_d  = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        state_d = S_CALC;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= S_IDLE;
            addr_q   <= 32'd0;
            remain_q <= 24'd0;
            len_q    <= '0;
            beat_q   <= 8'd0;
            done_q   <= 1'b0;
            error_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            remain_q <= remain_d;
            len_q    <= len_d;
            beat_q   <= beat_d;
            done_q   <= done_d;
            error_q  <= error_d;
        end
    end

    assign busy_o        = (state_q != S_IDLE);
    assign done_o        = done_q;
    assign error_o       = error_q;
    assign fifo_pop_o    = wvalid_c && axi_wready_i;
    assign axi_awvalid_o = (state_q == S_ADDR);
    assign axi_awaddr_o  = addr_q;
    assign axi_awid_o    = AXI_ID;
    assign axi_awlen_o   = 8'(len_q - LEN_W'(1));
    assign axi_awburst_o = 2'b01;
    assign axi_wvalid_o  = wvalid_c;
    assign axi_wdata_o   = fifo_data_i;
    assign axi_wstrb_o   = 4'hF;
    assign axi_wlast_o   = wlast_c;
    assign axi_bready_o  = 1'b1;

endmodule

// File: tb/tb_jpeg_decoder_axi_writer.sv
// Scoreboard bench for jpeg_decoder_axi_writer: FIFO/AXI slave models feed a negedge monitor.
module tb_jpeg_decoder_axi_writer;

    logic        clk = 1'b0;
    logic        rst_i, cfg_start_i;
    logic [31:0] cfg_base_addr_i;
    logic [23:0] cfg_words_i;
    logic        busy_o, done_o, error_o;
    logic [31:0] fifo_data_i;
    logic        fifo_valid_i;
    logic [10:0] fifo_level_i;
    logic        fifo_pop_o;
    logic        axi_awvalid_o, axi_awready_i;
    logic [31:0] axi_awaddr_o;
    logic [3:0]  axi_awid_o;
    logic [7:0]  axi_awlen_o;
    logic [1:0]  axi_awburst_o;
    logic        axi_wvalid_o, axi_wlast_o, axi_wready_i;
    logic [31:0] axi_wdata_o;
    logic [3:0]  axi_wstrb_o;
    logic        axi_bvalid_i, axi_bready_o;
    logic [1:0]  axi_bresp_i;
    logic [3:0]  axi_bid_i;

    jpeg_decoder_axi_writer dut (
        .clk_i(clk), .rst_i(rst_i), .cfg_start_i(cfg_start_i),
        .cfg_base_addr_i(cfg_base_addr_i), .cfg_words_i(cfg_words_i),
        .busy_o(busy_o), .done_o(done_o), .error_o(error_o),
        .fifo_data_i(fifo_data_i), .fifo_valid_i(fifo_valid_i),
        .fifo_level_i(fifo_level_i), .fifo_pop_o(fifo_pop_o),
        .axi_awvalid_o(axi_awvalid_o), .axi_awaddr_o(axi_awaddr_o),
        .axi_awid_o(axi_awid_o), .axi_awlen_o(axi_awlen_o),
        .axi_awburst_o(axi_awburst_o), .axi_awready_i(axi_awready_i),
        .axi_wvalid_o(axi_wvalid_o), .axi_wdata_o(axi_wdata_o),
        .axi_wstrb_o(axi_wstrb_o), .axi_wlast_o(axi_wlast_o),
        .axi_wready_i(axi_wready_i), .axi_bvalid_i(axi_bvalid_i),
        .axi_bresp_i(axi_bresp_i), .axi_bid_i(axi_bid_i),
        .axi_bready_o(axi_bready_o)
    );

    always #5 clk = ~clk;

    typedef struct packed {logic [31:0] addr; logic [7:0] len;} aw_t;
    typedef struct packed {logic [31:0] data; logic last;} w_t;

    aw_t         exp_aw[$];
    w_t          exp_w[$];
    logic [31:0] fq[$];
    int unsigned checks = 0, errors = 0;
    int unsigned exp_done = 0, done_cnt = 0;
    logic        exp_err = 1'b0;
    int unsigned aw_cnt = 0, wl_cnt = 0, b_cnt = 0, pop_cnt = 0, err_on_b = 0;
    bit          rand_en = 0, lag_en = 0;
    int unsigned lag = 2;
    logic [31:0] fill_ctr, exp_ctr, m_junk;
    logic        m_pop, m_aw, m_wl, m_b;
    logic        aw_hold = 1'b0;
    aw_t         aw_prev, e_aw;
    w_t          e_w;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endfunction

    // FIFO with optional read latency, plus AXI slave ready/response generation.
    always @(posedge clk) begin
        m_pop = fifo_pop_o;
        m_aw  = axi_awvalid_o && axi_awready_i;
        m_wl  = axi_wvalid_o && axi_wready_i && axi_wlast_o;
        m_b   = axi_bvalid_i && axi_bready_o;
        #1;
        if (m_pop && fq.size() != 0) begin
            m_junk = fq.pop_front();
            pop_cnt++;
        end
        if (m_aw) aw_cnt++;
        if (m_wl) wl_cnt++;
        if (m_b) begin
            b_cnt++;
            axi_bvalid_i = 1'b0;
            axi_bresp_i  = 2'b00;
        end
        if (m_pop) lag = 0;
        else if (lag < 2) lag++;
        fifo_valid_i  = (fq.size() != 0) && (!lag_en || lag >= 2);
        fifo_data_i   = (fq.size() != 0) ? fq[0] : 32'd0;
        fifo_level_i  = 11'(fq.size());
        axi_awready_i = !rand_en || ($urandom_range(0, 1) == 1);
        axi_wready_i  = !rand_en || ($urandom_range(0, 1) == 1);
        if (!axi_bvalid_i && wl_cnt > b_cnt && (!rand_en || $urandom_range(0, 2) == 0)) begin
            axi_bvalid_i = 1'b1;
            axi_bresp_i  = (b_cnt + 1 == err_on_b) ? 2'b10 : 2'b00;
        end
    end

    // Monitor: handshakes are stable at negedge and complete at the following posedge.
    always @(negedge clk) begin
        if (!rst_i) begin
            if (axi_wvalid_o && !fifo_valid_i) chk("wvalid_without_fifo_valid", 1, 0);
            if (aw_hold) begin
                chk("aw_stable_valid", 32'(axi_awvalid_o), 1);
                chk("aw_stable_addr", axi_awaddr_o, aw_prev.addr);
                chk("aw_stable_len", 32'(axi_awlen_o), 32'(aw_prev.len));
            end
            aw_hold = axi_awvalid_o && !axi_awready_i;
            aw_prev = '{addr: axi_awaddr_o, len: axi_awlen_o};
            if (axi_awvalid_o && axi_awready_i) begin
                if (exp_aw.size() == 0) begin
                    chk("aw_unexpected", axi_awaddr_o, 32'hFFFF_FFFF);
                end else begin
                    e_aw = exp_aw.pop_front();
                    chk("aw_addr", axi_awaddr_o, e_aw.addr);
                    chk("aw_len", 32'(axi_awlen_o), 32'(e_aw.len));
                end
                chk("aw_id_burst", {axi_awid_o, axi_awburst_o}, {4'd0, 2'b01});
                chk("aw_outstanding", aw_cnt - b_cnt, 0);
                chk("aw_level_ready", 32'(int'(fifo_level_i) >= int'(axi_awlen_o) + 1), 1);
            end
            if (axi_wvalid_o && axi_wready_i) begin
                if (exp_w.size() == 0) begin
                    chk("w_unexpected", axi_wdata_o, 32'hFFFF_FFFF);
                end else begin
                    e_w = exp_w.pop_front();
                    chk("w_data", axi_wdata_o, e_w.data);
                    chk("w_last", 32'(axi_wlast_o), 32'(e_w.last));
                end
                chk("w_strb", 32'(axi_wstrb_o), 32'hF);
                chk("w_after_aw", aw_cnt - b_cnt, 1);
            end
            if (done_o) begin
                done_cnt++;
                chk("done_expected", 32'(exp_done > 0), 1);
                if (exp_done > 0) exp_done--;
                chk("error_at_done", 32'(error_o), 32'(exp_err));
            end
        end
    end

    task automatic exp_burst(input logic [31:0] addr, input int unsigned len);
        exp_aw.push_back('{addr: addr, len: 8'(len - 1)});
        for (int i = 0; i < int'(len); i++) begin
            exp_w.push_back('{data: exp_ctr, last: (i == int'(len) - 1)});
            exp_ctr++;
        end
    endtask

    task automatic fill(input int n);
        for (int i = 0; i < n; i++) begin
            fq.push_back(fill_ctr);
            fill_ctr++;
        end
    endtask

    task automatic new_test(input logic [31:0] seed);
        fill_ctr = seed;
        exp_ctr  = seed;
    endtask

    task automatic start_xfer(input logic [31:0] base, input logic [23:0] words, input bit counted);
        @(posedge clk); #1;
        cfg_base_addr_i = base;
        cfg_words_i     = words;
        cfg_start_i     = 1'b1;
        if (counted) exp_done++;
        @(posedge clk); #1;
        cfg_start_i = 1'b0;
    endtask

    task automatic wait_done(input int unsigned target, input int budget, input string name);
        int n = 0;
        while (done_cnt < target && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk(name, 32'(done_cnt >= target), 1);
        repeat (4) @(negedge clk);
        chk({name, "_aw_drained"}, exp_aw.size(), 0);
        chk({name, "_w_drained"}, exp_w.size(), 0);
        chk({name, "_idle"}, 32'(busy_o), 0);
    endtask

    int unsigned tgt, aw0, pop0;

    initial begin
        rst_i = 1'b1; cfg_start_i = 1'b0; cfg_base_addr_i = 32'd0; cfg_words_i = 24'd0;
        fifo_data_i = 32'd0; fifo_valid_i = 1'b0; fifo_level_i = 11'd0;
        axi_awready_i = 1'b1; axi_wready_i = 1'b1; axi_bvalid_i = 1'b0;
        axi_bresp_i = 2'b00; axi_bid_i = 4'd0;
        repeat (3) @(posedge clk); #1;
        chk("rst_busy", 32'(busy_o), 0);
        chk("rst_done", 32'(done_o), 0);
        chk("rst_error", 32'(error_o), 0);
        chk("rst_pop", 32'(fifo_pop_o), 0);
        chk("rst_awvalid", 32'(axi_awvalid_o), 0);
        chk("rst_wvalid", 32'(axi_wvalid_o), 0);
        chk("rst_awaddr", axi_awaddr_o, 0);
        chk("rst_bready", 32'(axi_bready_o), 1);
        rst_i = 1'b0;

        // Three bursts from a pre-filled FIFO.
        new_test(32'hA100_0000);
        fill(40);
        exp_burst(32'h1000_0000, 16);
        exp_burst(32'h1000_0040, 16);
        exp_burst(32'h1000_0080, 8);
        tgt = done_cnt + 1;
        start_xfer(32'h1000_0000, 24'd40, 1);
        wait_done(tgt, 500, "t1_done");

        // 4KB page split; low address bits dropped.
        new_test(32'hA200_0000);
        fill(8);
        exp_burst(32'h0000_0FF0, 4);
        exp_burst(32'h0000_1000, 4);
        tgt = done_cnt + 1;
        start_xfer(32'h0000_0FF2, 24'd8, 1);
        wait_done(tgt, 300, "t2_done");

        // Slow FIFO fill with read latency; a second start while busy is ignored.
        new_test(32'hA300_0000);
        lag_en = 1;
        pop0 = pop_cnt;
        exp_burst(32'h2000_0000, 16);
        tgt = done_cnt + 1;
        start_xfer(32'h2000_0000, 24'd16, 1);
        start_xfer(32'h5000_0000, 24'd5, 0);
        for (int i = 0; i < 16; i++) begin
            repeat (3) @(posedge clk); #1;
            fill(1);
        end
        wait_done(tgt, 500, "t3_done");
        chk("t3_pops", pop_cnt - pop0, 16);

        // Random back-pressure across a page boundary.
        new_test(32'hA400_0000);
        rand_en = 1;
        fill(100);
        exp_burst(32'h3000_0FC0, 16);
        exp_burst(32'h3000_1000, 16);
        exp_burst(32'h3000_1040, 16);
        exp_burst(32'h3000_1080, 16);
        exp_burst(32'h3000_10C0, 16);
        exp_burst(32'h3000_1100, 16);
        exp_burst(32'h3000_1140, 4);
        tgt = done_cnt + 1;
        start_xfer(32'h3000_0FC0, 24'd100, 1);
        wait_done(tgt, 5000, "t4_done");
        rand_en = 0;
        lag_en  = 0;

        // Zero-length transfer completes immediately without AXI traffic.
        aw0 = aw_cnt;
        @(posedge clk); #1;
        cfg_base_addr_i = 32'h6000_0000; cfg_words_i = 24'd0; cfg_start_i = 1'b1;
        exp_done++;
        @(posedge clk); #1;
        cfg_start_i = 1'b0;
        chk("t5_done_pulse", 32'(done_o), 1);
        chk("t5_busy", 32'(busy_o), 0);
        @(posedge clk); #1;
        chk("t5_done_cleared", 32'(done_o), 0);
        chk("t5_busy_after", 32'(busy_o), 0);
        repeat (3) @(posedge clk);
        chk("t5_no_aw", aw_cnt - aw0, 0);

`ifdef JPEG_DECODER_AXI_WR_ERROR_EN
        // Second B is SLVERR: stop after two bursts, leave the rest in the FIFO.
        new_test(32'hA600_0000);
        fill(48);
        exp_burst(32'h4000_0000, 16);
        exp_burst(32'h4000_0040, 16);
        err_on_b = b_cnt + 2;
        exp_err  = 1'b1;
        tgt = done_cnt + 1;
        start_xfer(32'h4000_0000, 24'd48, 1);
        wait_done(tgt, 500, "t6_done");
        chk("t6_error_sticky", 32'(error_o), 1);
        chk("t6_fifo_left", 32'(fifo_level_i), 16);
        err_on_b = 0;
        exp_err  = 1'b0;
        fq.delete();
        tgt = done_cnt + 1;
        start_xfer(32'h4000_1000, 24'd0, 1);
        wait_done(tgt, 50, "t6_restart_done");
        chk("t6_error_cleared", 32'(error_o), 0);
`endif

        chk("final_done_balance", exp_done, 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
